// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register file write port among N_REQ requesters,
// with a clear sequencer that zeroes every register after reset and on clr_req.
module regfile_write_arbiter #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 12,
    parameter int ADDR_W = 3,
    parameter int ID_W   = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr_req,
    output logic                     clr_busy,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [N_REQ*ADDR_W-1:0]  req_addr,
    input  logic [N_REQ*DATA_W-1:0]  req_data,
    output logic [N_REQ-1:0]         req_ready,
    output logic                     rf_write_en,
    output logic [ADDR_W-1:0]        rf_write_addr,
    output logic [DATA_W-1:0]        rf_data_in,
    output logic [ID_W-1:0]          rf_grant_id
);

    localparam int NUM_REGS = 2 ** ADDR_W;
    localparam logic [ID_W:0] NREQ_W = (ID_W+1)'(N_REQ);

    typedef enum logic {CLEAR = 1'b0, ARB = 1'b1} state_t;

    state_t             state_q;
    logic [ADDR_W-1:0]  clr_cnt_q;
    logic [ID_W-1:0]    rr_ptr_q;
    logic [ID_W-1:0]    rr_ptr_d;
    logic               we_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [DATA_W-1:0]  data_q;
    logic [ID_W-1:0]    gid_q;
    logic               busy_q;

    logic               gnt_found;
    logic [ID_W-1:0]    gnt_idx;
    logic [ID_W:0]      cand;
    logic [ID_W:0]      ptr_inc;
    logic [ADDR_W-1:0]  gnt_addr;
    logic [DATA_W-1:0]  gnt_data;

    // Search starts at rr_ptr and wraps modulo N_REQ; the first valid requester wins.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        if (state_q == ARB && !clr_req) begin
            for (int k = 0; k < N_REQ; k++) begin
                cand = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
                if (cand >= NREQ_W)
                    cand = cand - NREQ_W;
                if (!gnt_found && req_valid[cand[ID_W-1:0]]) begin
                    gnt_found = 1'b1;
                    gnt_idx   = cand[ID_W-1:0];
                end
            end
        end
    end

    always_comb begin
        req_ready = '0;
        gnt_addr  = '0;
        gnt_data  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt_found && ID_W'(i) == gnt_idx) begin
                req_ready[i] = 1'b1;
                gnt_addr     = req_addr[i*ADDR_W +: ADDR_W];
                gnt_data     = req_data[i*DATA_W +: DATA_W];
            end
        end
        ptr_inc  = {1'b0, gnt_idx} + 1'b1;
        rr_ptr_d = (ptr_inc >= NREQ_W) ? '0 : ptr_inc[ID_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= CLEAR;
            clr_cnt_q <= '0;
            rr_ptr_q  <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            gid_q     <= '0;
            busy_q    <= 1'b1;
        end else begin
            case (state_q)
                CLEAR: begin
                    we_q      <= 1'b1;
                    addr_q    <= clr_cnt_q;
                    data_q    <= '0;
                    gid_q     <= '0;
                    clr_cnt_q <= clr_cnt_q + 1'b1;
                    if (clr_cnt_q == ADDR_W'(NUM_REGS - 1)) begin
                        state_q   <= ARB;
                        clr_cnt_q <= '0;
                        busy_q    <= 1'b0;
                    end
                end
                ARB: begin
                    if (clr_req) begin
                        // First zero write lands one cycle after entering CLEAR.
                        state_q   <= CLEAR;
                        clr_cnt_q <= '0;
                        busy_q    <= 1'b1;
                        we_q      <= 1'b0;
                    end else if (gnt_found) begin
                        we_q     <= 1'b1;
                        addr_q   <= gnt_addr;
                        data_q   <= gnt_data;
                        gid_q    <= gnt_idx;
                        rr_ptr_q <= rr_ptr_d;
                    end else begin
                        we_q <= 1'b0;
                    end
                end
                default: state_q <= CLEAR;
            endcase
        end
    end

    assign rf_write_en   = we_q;
    assign rf_write_addr = addr_q;
    assign rf_data_in    = data_q;
    assign rf_grant_id   = gid_q;
    assign clr_busy      = busy_q;

endmodule
